xb_stream_gen: RTL and testbench

- Command-driven test-stream generator between the host-to-FPGA command FIFO (first-word-fall-through, 32-bit words) and a host-bound read FIFO.
- Each accepted command selects a pattern mode and a word count, then streams that many DATA_W-bit words into the read FIFO under full backpressure.
- A STOP command aborts the current stream and raises the end-of-file indication toward the host channel.
- Parametrised in data width, command width and LFSR seed.

---
 rtl/xb_stream_gen.sv | 153 +++++++++++++++
 tb/tb_xb_stream_gen.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xb_stream_gen.sv
// Command-driven test-stream generator: pops commands from a FWFT FIFO and
// streams DOWN/UP/LFSR word sequences into a host-bound FIFO with backpressure.
module xb_stream_gen #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned CMD_W     = 32,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2468,
    parameter int unsigned FCNT_W    = 16
) (
    input  logic              bus_clk,
    input  logic              reset,
    input  logic [CMD_W-1:0]  cmd_dout,
    input  logic              cmd_empty,
    output logic              cmd_ack,
    output logic [DATA_W-1:0] out_data,
    output logic              out_wren,
    input  logic              out_full,
    output logic              eof,
    output logic              busy,
    output logic              done,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int unsigned CNT_W     = CMD_W - 2;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    typedef enum logic [1:0] {
        MODE_STOP = 2'd0,
        MODE_DOWN = 2'd1,
        MODE_UP   = 2'd2,
        MODE_LFSR = 2'd3
    } mode_t;

    state_t             state_q, state_d;
    mode_t              mode_q, mode_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [31:0]        lfsr_q, lfsr_d;
    logic [DATA_W-1:0]  data_d;
    logic               ack_d, eof_d, done_d;
    logic [FCNT_W-1:0]  fcnt_d;

    mode_t              cmd_mode;
    logic [CNT_W-1:0]   cmd_count;
    logic               cmd_avail;
    logic               stop_head;
    logic [31:0]        lfsr_adv;

    // The head word is stale while cmd_ack is high, so it is masked for that cycle.
    assign cmd_mode  = mode_t'(cmd_dout[CMD_W-1:CMD_W-2]);
    assign cmd_count = cmd_dout[CNT_W-1:0];
    assign cmd_avail = !cmd_empty && !cmd_ack;
    assign stop_head = cmd_avail && (cmd_mode == MODE_STOP);
    assign out_wren  = (state_q == RUN) && !out_full && !stop_head && !reset;
    assign busy      = (state_q == RUN);

    // Right-shifting Galois step
    assign lfsr_adv  = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        remaining_d = remaining_q;
        lfsr_d      = lfsr_q;
        data_d      = out_data;
        ack_d       = 1'b0;
        eof_d       = eof;
        done_d      = 1'b0;
        fcnt_d      = frame_cnt;

        case (state_q)
            IDLE: begin
                if (cmd_avail) begin
                    ack_d = 1'b1;
                    if (cmd_mode == MODE_STOP) begin
                        eof_d = 1'b1;
                    end else begin
                        eof_d       = 1'b0;
                        mode_d      = cmd_mode;
                        remaining_d = cmd_count;
                        case (cmd_mode)
                            MODE_DOWN: data_d = DATA_W'(cmd_count);
                            MODE_UP:   data_d = '0;
                            MODE_LFSR: data_d = DATA_W'(lfsr_q);
                            default:   data_d = out_data;
                        endcase
                        if (cmd_count != '0) begin
                            state_d = RUN;
                        end else begin
                            done_d = 1'b1;
                            fcnt_d = frame_cnt + FCNT_W'(1);
                        end
                    end
                end
            end

            RUN: begin
                // A STOP at the head aborts the stream and pre-empts any write.
                if (stop_head) begin
                    ack_d   = 1'b1;
                    eof_d   = 1'b1;
                    state_d = IDLE;
                end else if (out_wren) begin
                    remaining_d = remaining_q - CNT_W'(1);
                    case (mode_q)
                        MODE_DOWN: data_d = out_data - DATA_W'(1);
                        MODE_UP:   data_d = out_data + DATA_W'(1);
                        MODE_LFSR: begin
                            lfsr_d = lfsr_adv;
                            data_d = DATA_W'(lfsr_adv);
                        end
                        default:   data_d = out_data;
                    endcase
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        fcnt_d  = frame_cnt + FCNT_W'(1);
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge bus_clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mode_q      <= MODE_STOP;
            remaining_q <= '0;
            lfsr_q      <= LFSR_SEED;
            out_data    <= '0;
            cmd_ack     <= 1'b0;
            eof         <= 1'b0;
            done        <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            remaining_q <= remaining_d;
            lfsr_q      <= lfsr_d;
            out_data    <= data_d;
            cmd_ack     <= ack_d;
            eof         <= eof_d;
            done        <= done_d;
            frame_cnt   <= fcnt_d;
        end
    end

endmodule

// File: tb/tb_xb_stream_gen.sv
// Directed bench for xb_stream_gen: a FWFT command FIFO model feeds the DUT
// and every write, ack and done pulse is logged per cycle for checking.
module tb_xb_stream_gen;

    logic        bus_clk;
    logic        reset;
    logic [31:0] cmd_dout;
    logic        cmd_empty;
    logic        cmd_ack;
    logic [31:0] out_data;
    logic        out_wren;
    logic        out_full;
    logic        eof;
    logic        busy;
    logic        done;
    logic [15:0] frame_cnt;

    xb_stream_gen dut (
        .bus_clk   (bus_clk),
        .reset     (reset),
        .cmd_dout  (cmd_dout),
        .cmd_empty (cmd_empty),
        .cmd_ack   (cmd_ack),
        .out_data  (out_data),
        .out_wren  (out_wren),
        .out_full  (out_full),
        .eof       (eof),
        .busy      (busy),
        .done      (done),
        .frame_cnt (frame_cnt)
    );

    initial bus_clk = 1'b0;
    always #5 bus_clk = ~bus_clk;

    int          n_cmp;
    int          n_bad;
    int          cyc;
    int          nwr_rst;
    logic [31:0] fifo[$];
    logic [31:0] wq[$];
    int          wcyc[$];
    int          acyc[$];
    int          dcyc[$];
    logic [31:0] lf[4];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] wr(input int i);
        return (i < wq.size()) ? 64'(wq[i]) : '1;
    endfunction

    function automatic logic [63:0] cyc_at(input int q[$], input int i);
        return (i < q.size()) ? 64'(q[i]) : '1;
    endfunction

    task automatic fifo_drive();
        cmd_empty = (fifo.size() == 0);
        cmd_dout  = (fifo.size() != 0) ? fifo[0] : 32'h0;
    endtask

    task automatic push(input logic [31:0] w);
        fifo.push_back(w);
        fifo_drive();
    endtask

    task automatic clear_logs();
        wq.delete();
        wcyc.delete();
        acyc.delete();
        dcyc.delete();
    endtask

    // One clock: observe at the falling edge, return just after the rising edge.
    task automatic step();
        @(negedge bus_clk);
        cyc++;
        if (out_wren) begin
            wq.push_back(out_data);
            wcyc.push_back(cyc);
            if (reset) nwr_rst++;
        end
        if (done) dcyc.push_back(cyc);
        if (cmd_ack) begin
            acyc.push_back(cyc);
            if (fifo.size() != 0) fifo.delete(0);
        end
        fifo_drive();
        @(posedge bus_clk);
        #1;
    endtask

    task automatic wait_writes(input int n, input int budget);
        int k;
        k = 0;
        while (wq.size() < n && k < budget) begin
            step();
            k++;
        end
        check("wait_writes", 64'(wq.size() >= n), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        cyc     = 0;
        nwr_rst = 0;
        lf[0]   = 32'hACE1_2468;
        lf[1]   = 32'h5670_9234;
        lf[2]   = 32'h2B38_491A;
        lf[3]   = 32'h159C_248D;
        reset    = 1'b1;
        out_full = 1'b0;
        fifo_drive();
        repeat (3) step();

        check("rst_ack",  64'(cmd_ack),   64'd0);
        check("rst_data", 64'(out_data),  64'd0);
        check("rst_eof",  64'(eof),       64'd0);
        check("rst_done", 64'(done),      64'd0);
        check("rst_fcnt", 64'(frame_cnt), 64'd0);
        check("rst_busy", 64'(busy),      64'd0);
        check("rst_wren", 64'(out_wren),  64'd0);
        reset = 1'b0;
        step();

        // DOWN 4: writes 4,3,2,1 back to back, done one cycle after the last.
        clear_logs();
        push(32'h4000_0004);
        repeat (10) step();
        check("t1_acks", 64'(acyc.size()), 64'd1);
        check("t1_nwr",  64'(wq.size()),   64'd4);
        for (int i = 0; i < 4; i++) check($sformatf("t1_w%0d", i), wr(i), 64'(4 - i));
        check("t1_first", cyc_at(wcyc, 0), cyc_at(acyc, 0));
        check("t1_last",  cyc_at(wcyc, 3), cyc_at(acyc, 0) + 64'd3);
        check("t1_ndone", 64'(dcyc.size()), 64'd1);
        check("t1_dcyc",  cyc_at(dcyc, 0), cyc_at(wcyc, 3) + 64'd1);
        check("t1_fcnt",  64'(frame_cnt), 64'd1);
        check("t1_eof",   64'(eof), 64'd0);

        // UP 3 with the read FIFO full for 5 cycles after the first write.
        clear_logs();
        push(32'h8000_0003);
        wait_writes(1, 10);
        out_full = 1'b1;
        repeat (5) step();
        check("t2_hold_nwr",  64'(wq.size()),   64'd1);
        check("t2_hold_done", 64'(dcyc.size()), 64'd0);
        check("t2_hold_busy", 64'(busy),        64'd1);
        out_full = 1'b0;
        repeat (8) step();
        check("t2_nwr", 64'(wq.size()), 64'd3);
        for (int i = 0; i < 3; i++) check($sformatf("t2_w%0d", i), wr(i), 64'(i));
        check("t2_ndone", 64'(dcyc.size()), 64'd1);
        check("t2_dcyc",  cyc_at(dcyc, 0), cyc_at(wcyc, 2) + 64'd1);
        check("t2_fcnt",  64'(frame_cnt), 64'd2);

        // Two queued LFSR 2 commands: sequence continues, second ack waits for done.
        clear_logs();
        push(32'hC000_0002);
        push(32'hC000_0002);
        repeat (14) step();
        check("t3_acks", 64'(acyc.size()), 64'd2);
        check("t3_nwr",  64'(wq.size()),   64'd4);
        for (int i = 0; i < 4; i++) check($sformatf("t3_w%0d", i), wr(i), 64'(lf[i]));
        check("t3_ndone", 64'(dcyc.size()), 64'd2);
        check("t3_ack2",  cyc_at(acyc, 1), cyc_at(dcyc, 0) + 64'd1);
        check("t3_fcnt",  64'(frame_cnt), 64'd4);

        // DOWN 100 aborted by STOP after 10 writes.
        clear_logs();
        push(32'h4000_0064);
        wait_writes(10, 30);
        push(32'h0000_0000);
        repeat (4) step();
        check("t4_nwr",   64'(wq.size()),   64'd10);
        check("t4_wlast", wr(9),            64'd91);
        check("t4_acks",  64'(acyc.size()), 64'd2);
        check("t4_eof",   64'(eof),         64'd1);
        check("t4_busy",  64'(busy),        64'd0);
        check("t4_ndone", 64'(dcyc.size()), 64'd0);
        check("t4_fcnt",  64'(frame_cnt),   64'd4);
        clear_logs();
        push(32'h8000_0001);
        repeat (6) step();
        check("t4_eof_clr", 64'(eof),        64'd0);
        check("t4_up_nwr",  64'(wq.size()),  64'd1);
        check("t4_up_w0",   wr(0),           64'd0);
        check("t4_up_fcnt", 64'(frame_cnt),  64'd5);

        // Zero-count command completes immediately.
        clear_logs();
        push(32'h8000_0000);
        repeat (5) step();
        check("t5_acks", 64'(acyc.size()), 64'd1);
        check("t5_nwr",  64'(wq.size()),   64'd0);
        check("t5_ndone", 64'(dcyc.size()), 64'd1);
        check("t5_dcyc", cyc_at(dcyc, 0), cyc_at(acyc, 0));
        check("t5_fcnt", 64'(frame_cnt), 64'd6);

        // Two STOPs while idle: both acked, eof stays high.
        clear_logs();
        push(32'h0000_0000);
        push(32'h0000_0000);
        repeat (6) step();
        check("t6_acks", 64'(acyc.size()), 64'd2);
        check("t6_gap",  cyc_at(acyc, 1), cyc_at(acyc, 0) + 64'd2);
        check("t6_eof",  64'(eof),         64'd1);
        check("t6_nwr",  64'(wq.size()),   64'd0);
        check("t6_fcnt", 64'(frame_cnt),   64'd6);

        // Reset in the middle of an UP 32 stream with a command queued.
        clear_logs();
        push(32'h8000_0020);
        wait_writes(3, 10);
        reset   = 1'b1;
        nwr_rst = 0;
        push(32'h4000_0002);
        repeat (3) step();
        check("t7_rst_wr",   64'(nwr_rst),     64'd0);
        check("t7_rst_acks", 64'(acyc.size()), 64'd1);
        check("t7_rst_data", 64'(out_data),    64'd0);
        check("t7_rst_busy", 64'(busy),        64'd0);
        check("t7_rst_fcnt", 64'(frame_cnt),   64'd0);
        check("t7_rst_eof",  64'(eof),         64'd0);
        check("t7_rst_ack",  64'(cmd_ack),     64'd0);
        reset = 1'b0;
        clear_logs();
        repeat (8) step();
        check("t7_acks", 64'(acyc.size()), 64'd1);
        check("t7_nwr",  64'(wq.size()),   64'd2);
        check("t7_w0",   wr(0),            64'd2);
        check("t7_w1",   wr(1),            64'd1);
        check("t7_fcnt", 64'(frame_cnt),   64'd1);
        clear_logs();
        push(32'hC000_0001);
        repeat (5) step();
        check("t7_seed", wr(0),          64'(lf[0]));
        check("t7_fcnt2", 64'(frame_cnt), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
